apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- APB initiator: turns single-beat commands on a simple valid/ready port into APB SETUP/ACCESS transfers on the bus.
- Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA; samples PRDATA/PREADY/PSLVERR.
- Pairs with the existing APB slave on the bus. Unlike that slave, it supports slaves that insert wait states via PREADY.
- Returns read data and error status as a one-cycle response pulse.

Parameters:
ADDRESS_WIDTH, 5, width of PADDR and cmd_addr
DATA_WIDTH, 8, width of PWDATA, PRDATA, cmd_wdata, rsp_rdata
TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN

Ports:
PCLK  in  1  single clock; all logic on rising edge
PRESET  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDRESS_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts
rsp_err  out  1  PSLVERR or timeout of the completed transfer
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDRESS_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
Reset:
- Sampled on a PCLK edge with PRESET=1.
- Forces state IDLE.
- Clears PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_err and the timeout counter.
- A transfer in flight is dropped with no response.

State machine (states IDLE, SETUP, ACCESS):
- IDLE: PSEL=0, PENABLE=0, cmd_ready=1.
- IDLE, on cmd_valid: capture cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA; next state SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; always goes to ACCESS after exactly one cycle.
- ACCESS: PSEL=1, PENABLE=1.
- ACCESS, PREADY=0: stay in ACCESS (wait state); cmd_ready=0; all APB outputs held stable.
- ACCESS, PREADY=1: transfer completes; cmd_ready=1 that cycle.
- On completion with cmd_valid=1: capture the new command, go directly to SETUP. PSEL stays 1; PENABLE drops to 0.
- On completion with cmd_valid=0: go to IDLE.

APB output rules:
- PADDR/PWRITE/PWDATA change only when a command is accepted; otherwise they hold their last value.
- PWDATA is loaded with 0 for read commands.

Response:
- rsp_valid is registered: high for exactly one cycle, on the cycle after the completing edge.
- rsp_rdata = PRDATA sampled at completion for reads; 0 for writes.
- rsp_err = PSLVERR sampled at completion.
- There is no response backpressure.
- PSLVERR is ignored in every cycle except the completing one.

Latency and throughput:
- Zero-wait slave: command accepted at edge N → SETUP cycle N+1, ACCESS cycle N+2, rsp_valid cycle N+3.
- Back-to-back commands: one transfer every 2 cycles.

Optional Feature:
Macro: APB_TIMEOUT_EN.
- Defined: a counter counts consecutive ACCESS cycles with PREADY=0.
- On reaching TIMEOUT_CYCLES: abort the transfer, PSEL=0, PENABLE=0 next cycle, state IDLE, one-cycle rsp_valid with rsp_err=1 and rsp_rdata=0.
- The counter clears on every entry to SETUP.
- Not defined: ACCESS waits indefinitely for PREADY; the counter logic is absent.

Test Plan:
- Write, zero-wait slave: cmd write addr 5'd0 data 8'hAA → PSEL high 2 cycles, PENABLE high 1 cycle (the second), PADDR=0, PWDATA=8'hAA stable throughout; rsp_valid 1 cycle, rsp_err=0, rsp_rdata=0.
- Read-back: cmd read addr 5'd0 → PWRITE=0, PWDATA=0; rsp_valid with rsp_rdata=8'hAA, rsp_err=0; 3 cycles from acceptance to rsp_valid.
- Wait states: slave holds PREADY=0 for 3 ACCESS cycles, read addr 5'd3 returning 8'h5C → ACCESS lasts 4 cycles, PADDR/PENABLE unchanged, cmd_ready=0 throughout; rsp_rdata=8'h5C one cycle after PREADY=1.
- Back-to-back: cmd_valid held with write 5'd1/8'h11 then read 5'd1 → PSEL never drops between transfers, PENABLE pattern 0,1,0,1, two rsp_valid pulses 2 cycles apart, second rsp_rdata=8'h11.
- Error and reset: slave returns PSLVERR=1 on completion → rsp_err=1. PRESET=1 asserted during an ACCESS wait state → next cycle PSEL=0, PENABLE=0, no rsp_valid, cmd_ready=1 after reset released.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16): PREADY tied 0 → after 16 ACCESS cycles PSEL drops, rsp_valid=1, rsp_err=1, rsp_rdata=0. Without the macro, PSEL stays 1 after 100 cycles.

Source files
------------

// File: rtl/apb_requester_if.sv
// apb_requester_if: bundles the command, response and APB bus signals of apb_requester.
// Latency: none (signal bundle only).
// Backpressure: cmd_ready qualifies cmd_valid; rsp_* carries no backpressure; PREADY stalls ACCESS.
// Ports (signals): cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata command side,
//   rsp_valid/rsp_rdata/rsp_err response side, PSEL/PENABLE/PADDR/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR APB side.
// Modports: master = requester view (drives APB and response), slave = environment view.
interface apb_requester_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]    cmd_wdata;

  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;

  logic                     PSEL;
  logic                     PENABLE;
  logic [ADDRESS_WIDTH-1:0] PADDR;
  logic                     PWRITE;
  logic [DATA_WIDTH-1:0]    PWDATA;
  logic [DATA_WIDTH-1:0]    PRDATA;
  logic                     PREADY;
  logic                     PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_requester.sv
// apb_requester: APB initiator turning single-beat valid/ready commands into SETUP/ACCESS transfers.
// Latency: accept at edge N -> SETUP N+1, ACCESS N+2 (+wait states), rsp_valid pulse after completion.
// Backpressure: cmd_ready only in IDLE or on the completing ACCESS cycle; responses are never stalled.
// Ports: PCLK clock, PRESET synchronous active-high reset, bus = apb_requester_if.master
//   (command in, one-cycle response out, APB master signals).
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
//   consecutive PREADY=0 cycles (response with rsp_err=1, rsp_rdata=0).
module apb_requester #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_requester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     cmd_acc;

  // A zero limit would abort every transfer before the slave is ever sampled; this
  // marker block shows up in the elaborated hierarchy when that misconfiguration occurs.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_not_positive
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the ACCESS cycle that is the TIMEOUT_CYCLES-th consecutive stall.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Ready in IDLE, or on the completing ACCESS cycle so a new command can chain
  // straight into SETUP without an idle bubble.
  assign bus.cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cmd_acc     = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_acc = bus.cmd_valid;
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          if (bus.cmd_valid) begin
            cmd_acc = 1'b1;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else begin
`ifdef APB_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            state_d     = IDLE;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // Accepting a command is the only way the address/direction/data registers move.
    if (cmd_acc) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = bus.cmd_addr;
      pwrite_d  = bus.cmd_write;
      pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: self-checking bench for apb_requester with a wait-state APB slave,
// a transaction-level reference model checked every cycle, and directed literal checks.
module tb_apb_requester;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  bit   chk_en;
  int   force_waits;   // -1: random 0..3 wait states per transfer
  int   err_force;     // -1: random PSLVERR on completion
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  apb_requester_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_requester #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB slave: memory plus per-transfer wait states chosen when SETUP is seen.
  logic [DW-1:0] smem [32];
  initial begin
    int wait_left;
    wait_left = 0;
    for (int i = 0; i < 32; i++) smem[i] = 8'(i * 37 + 5);
    bus.PREADY  = 1'b0;
    bus.PRDATA  = '0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst && bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
        smem[bus.PADDR] = bus.PWDATA;
      #1;
      if (bus.PSEL && !bus.PENABLE)
        wait_left = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
      if (bus.PSEL && bus.PENABLE) begin
        if (wait_left > 0) begin
          wait_left--;
          bus.PREADY  = 1'b0;
          bus.PRDATA  = 8'($urandom);
          bus.PSLVERR = 1'($urandom);
        end else begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = bus.PWRITE ? 8'($urandom) : smem[bus.PADDR];
          bus.PSLVERR = (err_force >= 0) ? 1'(err_force) : ($urandom_range(0, 7) == 0);
        end
      end else begin
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = 8'($urandom);
        bus.PSLVERR = 1'($urandom);
      end
    end
  end

  // Reference model: one transfer in flight, tracked by its age since acceptance
  // (age 1 = setup cycle, age >= 2 = access), plus a mirror of slave memory.
  initial begin
    logic [DW-1:0] m_mem [32];
    bit            m_busy, m_rsp, nxt_rsp, accept;
    int            m_age, m_stall;
    logic [AW-1:0] m_addr;
    logic          m_write, m_rsp_er;
    logic [DW-1:0] m_wdata, m_rsp_rd;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'(i * 37 + 5);
    m_busy = 0; m_rsp = 0; m_age = 0; m_stall = 0;
    m_addr = '0; m_write = 1'b0; m_wdata = '0; m_rsp_rd = '0; m_rsp_er = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_psel", 32'(bus.PSEL), 32'(m_busy));
        chk("model_penable", 32'(bus.PENABLE), 32'(m_busy && m_age >= 2));
        chk("model_addr_dir_wdata", 32'({bus.PADDR, bus.PWRITE, bus.PWDATA}),
            32'({m_addr, m_write, m_wdata}));
        chk("model_cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy || (m_age >= 2 && bus.PREADY)));
        chk("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
        if (m_rsp)
          chk("model_rsp_rdata_err", 32'({bus.rsp_rdata, bus.rsp_err}), 32'({m_rsp_rd, m_rsp_er}));
      end
      nxt_rsp = 0;
      accept  = 0;
      if (rst) begin
        m_busy = 0; m_age = 0; m_stall = 0;
        m_addr = '0; m_write = 1'b0; m_wdata = '0;
      end else begin
        if (!m_busy) begin
          accept = bus.cmd_valid;
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (bus.PREADY) begin
          nxt_rsp  = 1;
          m_rsp_rd = m_write ? '0 : m_mem[m_addr];
          m_rsp_er = bus.PSLVERR;
          if (m_write && !bus.PSLVERR) m_mem[m_addr] = m_wdata;
          if (bus.cmd_valid) accept = 1;
          else m_busy = 0;
        end else begin
          m_stall++;
`ifdef APB_TIMEOUT_EN
          if (m_stall == TO) begin
            m_busy = 0; nxt_rsp = 1; m_rsp_rd = '0; m_rsp_er = 1'b1;
          end
`endif
        end
        if (accept) begin
          m_busy = 1; m_age = 1; m_stall = 0;
          m_addr = bus.cmd_addr; m_write = bus.cmd_write;
          m_wdata = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end
      m_rsp = nxt_rsp;
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    acc = 0; n = 0;
    while (!acc && n < 30) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(acc), 32'(1));
  endtask

  // Issues one command and observes it until the response pulse (lat = -1 if none).
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output int npsel, output int npen,
                         output logic [DW-1:0] rd, output logic er, output bit stable,
                         output bit rdy_in_wait);
    bit done;
    send(w, a, d);
    lat = 0; npsel = 0; npen = 0; rd = '0; er = 1'b0; stable = 1; rdy_in_wait = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.PSEL) begin
        npsel++;
        if (bus.PADDR !== a || bus.PWRITE !== w || bus.PWDATA !== (w ? d : 8'h00)) stable = 0;
      end
      if (bus.PENABLE) begin
        npen++;
        if (!bus.PREADY && bus.cmd_ready) rdy_in_wait = 1;
      end
      if (bus.rsp_valid) begin
        done = 1; rd = bus.rsp_rdata; er = bus.rsp_err;
      end
    end
    if (!done) lat = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: end of test not reached, required within time limit");
    $fatal(1);
  end

  initial begin
    int lat, npsel, npen;
    logic [DW-1:0] rd;
    logic er;
    bit stable, rdy_bad, acc;
    logic [4:0] ps_v, pe_v, rv_v;
    logic [DW-1:0] rd2, rd4;
    logic r2;

    rst = 1'b1; chk_en = 0; force_waits = 0; err_force = 0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    chk("reset_psel_penable", 32'({bus.PSEL, bus.PENABLE}), 32'(0));
    chk("reset_addr_dir_wdata", 32'({bus.PADDR, bus.PWRITE, bus.PWDATA}), 32'(0));
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait write then read-back.
    run_cmd(1'b1, 5'd0, 8'hAA, lat, npsel, npen, rd, er, stable, rdy_bad);
    chk("wr_latency", 32'(lat), 32'(3));
    chk("wr_psel_cycles", 32'(npsel), 32'(2));
    chk("wr_penable_cycles", 32'(npen), 32'(1));
    chk("wr_rsp", 32'({rd, er}), 32'(0));
    chk("wr_stable", 32'(stable), 32'(1));
    run_cmd(1'b0, 5'd0, 8'h3B, lat, npsel, npen, rd, er, stable, rdy_bad);
    chk("rd_latency", 32'(lat), 32'(3));
    chk("rd_rsp", 32'({rd, er}), 32'({8'hAA, 1'b0}));
    chk("rd_pwdata_zero_stable", 32'(stable), 32'(1));

    // Three wait states on a read.
    run_cmd(1'b1, 5'd3, 8'h5C, lat, npsel, npen, rd, er, stable, rdy_bad);
    force_waits = 3;
    run_cmd(1'b0, 5'd3, 8'h00, lat, npsel, npen, rd, er, stable, rdy_bad);
    chk("wait_latency", 32'(lat), 32'(6));
    chk("wait_penable_cycles", 32'(npen), 32'(4));
    chk("wait_rsp", 32'({rd, er}), 32'({8'h5C, 1'b0}));
    chk("wait_stable", 32'(stable), 32'(1));
    chk("wait_cmd_ready_low", 32'(rdy_bad), 32'(0));

    // Back-to-back: write 1/11 then read 1 with cmd_valid held.
    force_waits = 0;
    send(1'b1, 5'd1, 8'h11);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 5'd1; bus.cmd_wdata = 8'h77;
    r2 = 1'b0; rd2 = '0; rd4 = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ps_v[4-k] = bus.PSEL; pe_v[4-k] = bus.PENABLE; rv_v[4-k] = bus.rsp_valid;
      if (k == 2) rd2 = bus.rsp_rdata;
      if (k == 4) rd4 = bus.rsp_rdata;
      if (k == 1) begin
        r2 = bus.cmd_ready;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
      end
    end
    chk("b2b_psel", 32'(ps_v[4:1]), 32'(4'b1111));
    chk("b2b_penable", 32'(pe_v[4:1]), 32'(4'b0101));
    chk("b2b_rsp_pulses", 32'(rv_v), 32'(5'b00101));
    chk("b2b_ready_at_completion", 32'(r2), 32'(1));
    chk("b2b_rdata", 32'({rd2, rd4}), 32'({8'h00, 8'h11}));

    // Slave error on completion.
    force_waits = 1; err_force = 1;
    run_cmd(1'b0, 5'd0, 8'h00, lat, npsel, npen, rd, er, stable, rdy_bad);
    chk("err_rsp", 32'({rd, er}), 32'({8'hAA, 1'b1}));
    chk("err_latency", 32'(lat), 32'(4));
    err_force = 0;

    // Reset during an ACCESS wait state drops the transfer silently.
    force_waits = 8;
    send(1'b0, 5'd2, 8'h00);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_psel", 32'({bus.PSEL, bus.PENABLE}), 32'(2'b11));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_post_bus", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'(0));
    chk("rst_post_ready", 32'(bus.cmd_ready), 32'(1));
    @(negedge clk);
    chk("rst_no_rsp", 32'(bus.rsp_valid), 32'(0));

`ifdef APB_TIMEOUT_EN
    force_waits = 1000;
    run_cmd(1'b0, 5'd4, 8'h00, lat, npsel, npen, rd, er, stable, rdy_bad);
    chk("tmo_latency", 32'(lat), 32'(TO + 2));
    chk("tmo_penable_cycles", 32'(npen), 32'(TO));
    chk("tmo_rsp", 32'({rd, er, bus.PSEL}), 32'({8'h00, 1'b1, 1'b0}));
    @(negedge clk);
    chk("tmo_single_pulse", 32'({bus.rsp_valid, bus.cmd_ready}), 32'(2'b01));
`else
    force_waits = 1000;
    send(1'b0, 5'd4, 8'h00);
    repeat (100) @(negedge clk);
    chk("no_tmo_still_access", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'(3'b110));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
`endif

    // Randomized traffic, checked by the model every cycle.
    force_waits = -1; err_force = -1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      if (!bus.cmd_valid || acc) begin
        bus.cmd_valid = ($urandom_range(0, 9) < 6);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 5'($urandom);
        bus.cmd_wdata = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.cmd_valid = 1'b0; force_waits = 0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
